// File: rtl/filt_mac_result_sink_if.sv
// Stream interface between the FIR MAC result port and the downstream sample consumer.
// The sink sits on the slave modport. The producer/consumer side, such as a bench, uses master.
interface filt_mac_result_sink_if #(
  parameter int gp_inp_width  = 37,
  parameter int gp_oup_width  = 16,
  parameter int gp_fifo_depth = 8,
  parameter int gp_cnt_width  = 16
) ();
  localparam int LW = $clog2(gp_fifo_depth) + 1;

  logic                    i_ena;
  logic [gp_inp_width-1:0] i_data;
  logic                    i_done;
  logic [gp_oup_width-1:0] o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic [LW-1:0]           o_level;
  logic [gp_cnt_width-1:0] o_drop_cnt;
  logic [gp_cnt_width-1:0] o_sat_cnt;

  modport slave (
    input  i_ena, i_data, i_done, i_ready,
    output o_data, o_valid, o_level, o_drop_cnt, o_sat_cnt
  );

  modport master (
    output i_ena, i_data, i_done, i_ready,
    input  o_data, o_valid, o_level, o_drop_cnt, o_sat_cnt
  );
endinterface

// File: rtl/filt_mac_result_sink.sv
// Output-side consumer for the FIR MAC filter.
// Each full-precision result is rounded half-up, shifted and saturated into a narrow sample.
// Samples are queued in a show-ahead FIFO and delivered on a valid/ready handshake.
// The block also keeps sticky drop and saturation counters.
module filt_mac_result_sink #(
  parameter int gp_inp_width  = 37,
  parameter int gp_shift      = 12,
  parameter int gp_oup_width  = 16,
  parameter int gp_fifo_depth = 8,
  parameter int gp_cnt_width  = 16
) (
  input logic                   i_clk,
  input logic                   i_rst_an,
  filt_mac_result_sink_if.slave bus
);
  localparam int IW = gp_inp_width;
  localparam int SW = gp_inp_width + 1;  // one guard bit so the rounding add cannot wrap
  localparam int OW = gp_oup_width;
  localparam int AW = $clog2(gp_fifo_depth);
  localparam int PW = AW + 1;            // extra pointer MSB separates full from empty
  localparam int CW = gp_cnt_width;

  localparam logic signed [SW-1:0] RND_C = $signed({{(SW-1){1'b0}}, 1'b1}) <<< (gp_shift - 1);
  localparam logic signed [SW-1:0] MAX_C = $signed({{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN_C = ~MAX_C;
  localparam logic [PW-1:0]        FULL_C = PW'(gp_fifo_depth);
  localparam logic [CW-1:0]        CNT_MAX_C = {CW{1'b1}};

  // Round half-up toward +inf, then shift arithmetically and clip to the output range.
  // The result is {sat_flag, sample}.
  function automatic logic [OW:0] round_sat(input logic [IW-1:0] raw);
    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] shr;
    ext = $signed({raw[IW-1], raw}) + RND_C;
    shr = ext >>> gp_shift;
    if (shr > MAX_C) begin
      round_sat = {1'b1, MAX_C[OW-1:0]};
    end else if (shr < MIN_C) begin
      round_sat = {1'b1, MIN_C[OW-1:0]};
    end else begin
      round_sat = {1'b0, shr[OW-1:0]};
    end
  endfunction

  logic            s1_vld_q, s1_vld_d;
  logic [OW-1:0]   s1_data_q, s1_data_d;
  logic            s1_sat_q, s1_sat_d;
  logic [OW-1:0]   mem_q [gp_fifo_depth];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   level_q, level_d;
  logic [OW-1:0]   o_data_q, o_data_d;
  logic            o_valid_q, o_valid_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   sat_cnt_q, sat_cnt_d;
  logic            pop_s, full_s, wr_s, drop_s;
  logic [PW-1:0]   remain_s;
  logic [OW:0]     rs_s;

  // Stage-1 next state: capture a rounded sample on an enabled done strobe.
  always_comb begin
    rs_s      = round_sat(bus.i_data);
    s1_vld_d  = bus.i_ena && bus.i_done;
    s1_data_d = s1_data_q;
    s1_sat_d  = s1_sat_q;
    if (s1_vld_d) begin
      s1_data_d = rs_s[OW-1:0];
      s1_sat_d  = rs_s[OW];
    end else begin
      s1_data_d = s1_data_q;
      s1_sat_d  = s1_sat_q;
    end
  end

  // FIFO control: pop, write or drop, then update the pointers, show-ahead head and counters.
  always_comb begin
    pop_s    = o_valid_q && bus.i_ready;
    full_s   = (level_q == FULL_C);
    wr_s     = s1_vld_q && (!full_s || pop_s);
    drop_s   = s1_vld_q && full_s && !pop_s;
    wr_ptr_d = wr_s  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = wr_ptr_d - rd_ptr_d;
    remain_s = level_q - PW'(pop_s);
    o_valid_d = (level_d != {PW{1'b0}});
    o_data_d  = o_data_q;
    if (!o_valid_d) begin
      o_data_d = o_data_q;               // empty: keep the last delivered value
    end else if (remain_s == {PW{1'b0}}) begin
      o_data_d = s1_data_q;              // only the incoming write is left as head
    end else begin
      o_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
    if (drop_s && (drop_cnt_q != CNT_MAX_C)) begin
      drop_cnt_d = drop_cnt_q + CW'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    if (wr_s && s1_sat_q && (sat_cnt_q != CNT_MAX_C)) begin
      sat_cnt_d = sat_cnt_q + CW'(1);
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // State registers: stage 1, pointers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= {OW{1'b0}};
      s1_sat_q   <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {PW{1'b0}};
      o_data_q   <= {OW{1'b0}};
      o_valid_q  <= 1'b0;
      drop_cnt_q <= {CW{1'b0}};
      sat_cnt_q  <= {CW{1'b0}};
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_sat_q   <= s1_sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      drop_cnt_q <= drop_cnt_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // FIFO storage. It needs no reset because the pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s1_data_q;
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_level    = level_q;
  assign bus.o_drop_cnt = drop_cnt_q;
  assign bus.o_sat_cnt  = sat_cnt_q;
endmodule

// File: tb/tb_filt_mac_result_sink.sv
// Directed bench for filt_mac_result_sink: reset, latency, rounding, saturation,
// overflow/drop, full-with-pop, disabled capture and asynchronous reset.
module tb_filt_mac_result_sink;
  localparam int IW = 37;
  localparam int OW = 16;
  localparam int DP = 8;
  localparam int CW = 16;

  logic clk;
  logic rst_an;
  int   n_tests;
  int   n_fail;

  filt_mac_result_sink_if #(.gp_inp_width(IW), .gp_oup_width(OW),
                            .gp_fifo_depth(DP), .gp_cnt_width(CW)) bus ();

  filt_mac_result_sink #(.gp_inp_width(IW), .gp_shift(12), .gp_oup_width(OW),
                         .gp_fifo_depth(DP), .gp_cnt_width(CW)) dut (
    .i_clk   (clk),
    .i_rst_an(rst_an),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input longint v);
    bus.i_data = IW'(v);
    bus.i_done = 1'b1;
    tick();
    bus.i_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_an = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", bus.o_valid); end
    n_tests++; if (bus.o_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", bus.o_data); end
    n_tests++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.o_level); end
    n_tests++; if (bus.o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", bus.o_drop_cnt); end
    n_tests++; if (bus.o_sat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_sat: got %0d expected 0", bus.o_sat_cnt); end
    #3 rst_an = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    bus.i_ready = 1'b0;
    push_one(64'sd409600);
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got valid %0d expected 0", bus.o_valid); end
    tick();
    n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0d expected 1", bus.o_valid); end
    n_tests++; if (bus.o_data !== 16'd100) begin n_fail++; $display("FAIL basic_data: got %0d expected 100", $signed(bus.o_data)); end
    n_tests++; if (bus.o_level !== 4'd1) begin n_fail++; $display("FAIL basic_level: got %0d expected 1", bus.o_level); end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid: got %0d expected 0", bus.o_valid); end
    n_tests++; if (bus.o_data !== 16'd100) begin n_fail++; $display("FAIL basic_hold: got %0d expected 100", $signed(bus.o_data)); end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL basic_empty_ready: got level %0d expected 0", bus.o_level); end
    n_tests++; if (bus.o_data !== 16'd100) begin n_fail++; $display("FAIL basic_empty_hold: got %0d expected 100", $signed(bus.o_data)); end
  endtask

  task automatic test_rounding;
    longint vin[4];
    int     exp[4];
    vin = '{64'sd2047, 64'sd2048, -64'sd2048, -64'sd2049};
    exp = '{0, 1, 0, -1};
    for (int i = 0; i < 4; i++) push_one(vin[i]);
    tick();
    n_tests++; if (bus.o_level !== 4'd4) begin n_fail++; $display("FAIL round_level: got %0d expected 4", bus.o_level); end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.o_valid !== 1'b1 || bus.o_data !== 16'(exp[i])) begin
        n_fail++; $display("FAIL round_%0d: got %0d valid %0d expected %0d", i, $signed(bus.o_data), bus.o_valid, exp[i]);
      end
      tick();
    end
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL round_drained: got valid %0d expected 0", bus.o_valid); end
    n_tests++; if (bus.o_sat_cnt !== 16'd0) begin n_fail++; $display("FAIL round_no_sat: got %0d expected 0", bus.o_sat_cnt); end
  endtask

  task automatic test_saturation;
    push_one(64'sd1073741824);
    push_one(-64'sd1073741824);
    tick();
    n_tests++; if (bus.o_sat_cnt !== 16'd2) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 2", bus.o_sat_cnt); end
    bus.i_ready = 1'b1;
    n_tests++; if (bus.o_data !== 16'h7FFF) begin n_fail++; $display("FAIL sat_max: got %0d expected 32767", $signed(bus.o_data)); end
    tick();
    n_tests++; if (bus.o_data !== 16'h8000) begin n_fail++; $display("FAIL sat_min: got %0d expected -32768", $signed(bus.o_data)); end
    tick();
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL sat_drained: got level %0d expected 0", bus.o_level); end
  endtask

  task automatic test_overflow;
    for (int k = 1; k <= 10; k++) push_one(longint'(k) * 64'sd4096);
    tick();
    n_tests++; if (bus.o_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", bus.o_level); end
    n_tests++; if (bus.o_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d expected 2", bus.o_drop_cnt); end
    n_tests++; if (bus.o_data !== 16'd1) begin n_fail++; $display("FAIL ovf_head_stable: got %0d expected 1", $signed(bus.o_data)); end
    n_tests++; if (bus.o_sat_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_sat_unchanged: got %0d expected 2", bus.o_sat_cnt); end
    bus.i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_tests++; if (bus.o_valid !== 1'b1 || bus.o_data !== 16'(k)) begin
        n_fail++; $display("FAIL ovf_drain_%0d: got %0d valid %0d expected %0d", k, $signed(bus.o_data), bus.o_valid, k);
      end
      tick();
    end
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got valid %0d expected 0", bus.o_valid); end
  endtask

  task automatic test_full_pop_write;
    for (int k = 11; k <= 18; k++) push_one(longint'(k) * 64'sd4096);
    tick();
    n_tests++; if (bus.o_level !== 4'd8) begin n_fail++; $display("FAIL fpw_fill: got level %0d expected 8", bus.o_level); end
    bus.i_data = IW'(64'sd19 * 64'sd4096);
    bus.i_done = 1'b1;
    tick();
    bus.i_done  = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_level !== 4'd8) begin n_fail++; $display("FAIL fpw_level: got %0d expected 8", bus.o_level); end
    n_tests++; if (bus.o_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL fpw_drop: got %0d expected 2", bus.o_drop_cnt); end
    bus.i_ready = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      n_tests++; if (bus.o_valid !== 1'b1 || bus.o_data !== 16'(k)) begin
        n_fail++; $display("FAIL fpw_drain_%0d: got %0d valid %0d expected %0d", k, $signed(bus.o_data), bus.o_valid, k);
      end
      tick();
    end
    bus.i_ready = 1'b0;
    n_tests++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL fpw_drained: got level %0d expected 0", bus.o_level); end
  endtask

  task automatic test_disabled;
    bus.i_ena = 1'b0;
    push_one(64'sd4096);
    push_one(64'sd1073741824);
    push_one(64'sd8192);
    tick();
    tick();
    bus.i_ena = 1'b1;
    n_tests++; if (bus.o_level !== 4'd0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL dis_level: got level %0d valid %0d expected 0 0", bus.o_level, bus.o_valid);
    end
    n_tests++; if (bus.o_sat_cnt !== 16'd2) begin n_fail++; $display("FAIL dis_sat: got %0d expected 2", bus.o_sat_cnt); end
    n_tests++; if (bus.o_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL dis_drop: got %0d expected 2", bus.o_drop_cnt); end
  endtask

  task automatic test_async_reset;
    push_one(64'sd4096);
    push_one(64'sd8192);
    push_one(64'sd12288);
    #2 rst_an = 1'b0;
    #1;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0d expected 0", bus.o_valid); end
    n_tests++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL arst_level: got %0d expected 0", bus.o_level); end
    n_tests++; if (bus.o_data !== 16'd0) begin n_fail++; $display("FAIL arst_data: got %0d expected 0", bus.o_data); end
    n_tests++; if (bus.o_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_drop: got %0d expected 0", bus.o_drop_cnt); end
    n_tests++; if (bus.o_sat_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_sat: got %0d expected 0", bus.o_sat_cnt); end
    @(posedge clk);
    #3 rst_an = 1'b1;
    tick();
    tick();
    n_tests++; if (bus.o_level !== 4'd0) begin n_fail++; $display("FAIL arst_inflight_lost: got level %0d expected 0", bus.o_level); end
    push_one(64'sd20480);
    tick();
    n_tests++; if (bus.o_valid !== 1'b1 || bus.o_data !== 16'd5) begin
      n_fail++; $display("FAIL arst_resume: got %0d valid %0d expected 5", $signed(bus.o_data), bus.o_valid);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_an      = 1'b0;
    bus.i_ena   = 1'b1;
    bus.i_data  = {IW{1'b0}};
    bus.i_done  = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_pop_write();
    test_disabled();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
